// File: rtl/i2c_tx_byte_feeder_if.sv
// Byte-feeder link: TX FIFO read side plus the SDA bit-engine handshake.
// master = feeder side, slave = FIFO/bit-engine side.
interface i2c_tx_byte_feeder_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_empty;
  logic              fifo_ren;
  logic              bit_tick;
  logic              sda_in;
  logic              sda_out;

  modport master (
    input  fifo_rdata,
    input  fifo_empty,
    input  bit_tick,
    input  sda_in,
    output fifo_ren,
    output sda_out
  );

  modport slave (
    output fifo_rdata,
    output fifo_empty,
    output bit_tick,
    output sda_in,
    input  fifo_ren,
    input  sda_out
  );
endinterface

// File: rtl/i2c_tx_byte_feeder.sv
// Pops TX FIFO bytes, shifts them MSB-first on bit_tick and samples the ACK slot; back-to-back bytes reload in the ACK cycle.
// Pops only when enable=1 and the FIFO is non-empty; NACK parks in NACK_HOLD until nack_clr.
module i2c_tx_byte_feeder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 abort,
  input  logic                 nack_clr,
  i2c_tx_byte_feeder_if.master bus,
  output logic                 busy,
  output logic                 byte_done,
  output logic                 nack,
  output logic [CNT_W-1:0]     ack_count
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    ACK       = 2'd2,
    NACK_HOLD = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic              nack_nxt;
  logic [CNT_W-1:0]  ack_cnt_nxt;
  logic              sda_q;
  logic              can_load;
  logic              load;
  logic              done;

  assign can_load = enable && !bus.fifo_empty;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    nack_nxt    = nack;
    ack_cnt_nxt = ack_count;
    load        = 1'b0;
    done        = 1'b0;

    if (abort) begin
      // Any in-flight byte is dropped along with a coincident tick.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          load = can_load;
        end
        SHIFT: begin
          if (bus.bit_tick) begin
            shreg_nxt = shreg << 1;
            if (bit_cnt == '0) begin
              state_nxt = ACK;
            end else begin
              bit_cnt_nxt = bit_cnt - 1'b1;
            end
          end
        end
        ACK: begin
          if (bus.bit_tick) begin
            done = 1'b1;
            if (!bus.sda_in) begin
              ack_cnt_nxt = ack_count + 1'b1;
              if (can_load) begin
                load = 1'b1;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              nack_nxt  = 1'b1;
              state_nxt = NACK_HOLD;
            end
          end
        end
        NACK_HOLD: begin
          if (nack_clr) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase

      if (nack_clr) begin
        nack_nxt = 1'b0;
      end

      if (load) begin
        shreg_nxt   = bus.fifo_rdata;
        bit_cnt_nxt = BC_W'(DATA_W - 1);
        state_nxt   = SHIFT;
      end
    end
  end

  // Strobes are combinational, so reset must mask them explicitly.
  assign bus.fifo_ren = load && !rst;
  assign byte_done    = done && !rst;
  assign bus.sda_out  = sda_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      sda_q     <= 1'b1;
      busy      <= 1'b0;
      nack      <= 1'b0;
      ack_count <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      sda_q     <= (state_nxt == SHIFT) ? shreg_nxt[DATA_W-1] : 1'b1;
      busy      <= (state_nxt != IDLE);
      nack      <= nack_nxt;
      ack_count <= ack_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_tx_byte_feeder.sv
// Randomised scoreboard bench for i2c_tx_byte_feeder: a FIFO/bit-engine driver queues expected
// bits and ACK-slot outcomes; a negedge monitor pops and compares them against the DUT.
module tb_i2c_tx_byte_feeder;

  logic       clk = 1'b0;
  logic       rst, enable, abort, nack_clr;
  logic       busy, byte_done, nack;
  logic [7:0] ack_count;
  logic       busy2, byte_done2, nack2;
  logic [1:0] ack_count2;

  i2c_tx_byte_feeder_if #(.DATA_W(8)) bus ();
  i2c_tx_byte_feeder_if #(.DATA_W(8)) bus2 ();

  assign bus2.fifo_rdata = bus.fifo_rdata;
  assign bus2.fifo_empty = bus.fifo_empty;
  assign bus2.bit_tick   = bus.bit_tick;
  assign bus2.sda_in     = bus.sda_in;

  i2c_tx_byte_feeder #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .abort(abort), .nack_clr(nack_clr),
    .bus(bus), .busy(busy), .byte_done(byte_done), .nack(nack), .ack_count(ack_count)
  );

  // Narrow-counter copy sharing the same stimulus, to exercise counter wrap.
  i2c_tx_byte_feeder #(.DATA_W(8), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .enable(enable), .abort(abort), .nack_clr(nack_clr),
    .bus(bus2), .busy(busy2), .byte_done(byte_done2), .nack(nack2), .ack_count(ack_count2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic is_ack;
    logic val;
  } sb_t;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] fifo_q[$];
  logic       exp_bits[$];
  sb_t        sb[$];
  bit         pop_seen  = 1'b0;
  bit         in_byte   = 1'b0;
  int         tick_idx  = 0;
  int         tick_pct  = 100;
  bit         nack_next = 1'b0;
  bit         abort_arm = 1'b0;
  bit         rand_en   = 1'b0;
  int         model_cnt = 0;
  bit         model_nack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  task automatic present();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_rdata = bus.fifo_empty ? 8'($urandom) : fifo_q[0];
  endtask

  // One clock: account for what the previous edge consumed, then drive the next inputs.
  task automatic cycle();
    bit         tk;
    sb_t        r;
    logic [7:0] dummy8;
    logic       dummy1;
    @(posedge clk);
    #1;
    if (rst) begin
      in_byte  = 1'b0;
      tick_idx = 0;
    end else begin
      if (abort) begin
        if (in_byte) for (int i = tick_idx; i < 8; i++) dummy1 = exp_bits.pop_front();
        in_byte = 1'b0;
      end else if (bus.bit_tick && in_byte) begin
        tick_idx++;
        if (tick_idx == 9) in_byte = 1'b0;
      end
      if (pop_seen) begin
        dummy8   = fifo_q.pop_front();
        in_byte  = 1'b1;
        tick_idx = 0;
      end
    end
    abort    = 1'b0;
    nack_clr = 1'b0;
    tk       = in_byte && ($urandom_range(99) < tick_pct);
    bus.bit_tick = tk;
    bus.sda_in   = 1'($urandom_range(1));
    if (tk && !rst) begin
      if (abort_arm && tick_idx == 3) begin
        abort     = 1'b1;
        abort_arm = 1'b0;
      end else if (tick_idx < 8) begin
        r.is_ack = 1'b0;
        r.val    = exp_bits.pop_front();
        sb.push_back(r);
      end else begin
        bus.sda_in = nack_next;
        r.is_ack   = 1'b1;
        r.val      = nack_next;
        sb.push_back(r);
      end
    end
    if (rst) bus.bit_tick = 1'($urandom_range(1));
    enable = rand_en ? ($urandom_range(7) != 0) : 1'b1;
    present();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || in_byte || exp_bits.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({name, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  always @(negedge clk) begin
    sb_t r;
    pop_seen = bus.fifo_ren;
    if (!rst) begin
      if (bus.fifo_empty) chk("ren_when_empty", 32'(bus.fifo_ren), 32'd0);
      chk("ack_count", 32'(ack_count), 32'(model_cnt % 256));
      chk("ack_count_w2", 32'(ack_count2), 32'(model_cnt % 4));
      chk("nack", 32'(nack), 32'(model_nack));
      if (bus.bit_tick && !abort) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          if (!r.is_ack) begin
            chk("data_bit", 32'(bus.sda_out), 32'(r.val));
            chk("byte_done_early", 32'(byte_done), 32'd0);
          end else begin
            chk("ack_slot_sda", 32'(bus.sda_out), 32'd1);
            chk("byte_done", 32'(byte_done), 32'd1);
            if (!r.val) begin
              chk("b2b_pop", 32'(bus.fifo_ren), 32'(enable && !bus.fifo_empty));
              model_cnt++;
            end else begin
              chk("nack_no_pop", 32'(bus.fifo_ren), 32'd0);
              model_nack = 1'b1;
            end
          end
        end
      end else if (byte_done) begin
        chk("byte_done_spurious", 32'(byte_done), 32'd0);
      end
      if (nack_clr) model_nack = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    int n;
    rst = 1'b1; enable = 1'b1; abort = 1'b0; nack_clr = 1'b0;
    bus.bit_tick = 1'b1; bus.sda_in = 1'b0;
    push_byte(8'hA5);
    present();

    // Reset held two edges with a byte waiting and ticks toggling.
    cycle();
    cycle();
    @(negedge clk);
    chk("rst_sda_out", 32'(bus.sda_out), 32'd1);
    chk("rst_fifo_ren", 32'(bus.fifo_ren), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_byte_done", 32'(byte_done), 32'd0);
    chk("rst_nack", 32'(nack), 32'd0);
    chk("rst_ack_count", 32'(ack_count), 32'd0);
    rst = 1'b0;
    bus.bit_tick = 1'b0;

    // Single byte 0xA5, ACKed.
    tick_pct = 60;
    drain("single", 200);
    @(negedge clk);
    chk("single_ack_count", 32'(ack_count), 32'd1);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_sda", 32'(bus.sda_out), 32'd1);

    // Back-to-back bytes.
    push_byte(8'h3C);
    push_byte(8'hFF);
    present();
    drain("b2b", 300);
    @(negedge clk);
    chk("b2b_ack_count", 32'(ack_count), 32'd3);
    chk("b2b_busy", 32'(busy), 32'd0);

    // NACK, then hold with data waiting, then clear.
    nack_next = 1'b1;
    push_byte(8'h80);
    present();
    drain("nack", 200);
    nack_next = 1'b0;
    @(negedge clk);
    chk("nack_set", 32'(nack), 32'd1);
    chk("nack_hold_busy", 32'(busy), 32'd1);
    push_byte(8'h11);
    present();
    repeat (20) cycle();
    @(negedge clk);
    chk("nack_hold_no_pop", 32'(fifo_q.size()), 32'd1);
    chk("nack_hold_busy2", 32'(busy), 32'd1);
    chk("nack_hold_sda", 32'(bus.sda_out), 32'd1);
    nack_clr = 1'b1;
    cycle();
    @(negedge clk);
    chk("nack_clr_nack", 32'(nack), 32'd0);
    chk("nack_clr_idle", 32'(busy), 32'd0);
    drain("after_nack", 200);
    @(negedge clk);
    chk("after_nack_ack_count", 32'(ack_count), 32'd4);

    // Abort on the 4th tick of 0x55.
    tick_pct  = 100;
    abort_arm = 1'b1;
    push_byte(8'h55);
    present();
    drain("abort", 100);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sda", 32'(bus.sda_out), 32'd1);
    chk("abort_ack_count", 32'(ack_count), 32'd4);
    chk("abort_arm_used", 32'(abort_arm), 32'd0);

    // Enabled with an empty FIFO.
    repeat (20) cycle();
    @(negedge clk);
    chk("empty_busy", 32'(busy), 32'd0);

    // Random traffic: bursty FIFO fill, variable tick rate, enable dropouts.
    rand_en = 1'b1;
    pushed  = 0;
    n       = 0;
    while ((pushed < 300 || fifo_q.size() != 0 || in_byte || exp_bits.size() != 0) && n < 40000) begin
      if (pushed < 300 && fifo_q.size() < 4 && $urandom_range(3) == 0) begin
        push_byte(8'($urandom));
        pushed++;
        present();
      end
      if ($urandom_range(63) == 0) tick_pct = 30 + $urandom_range(70);
      cycle();
      n++;
    end
    chk("random_timeout", 32'(n < 40000), 32'd1);
    repeat (2) cycle();
    @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_ack_count", 32'(ack_count), 32'(304 % 256));
    chk("final_ack_count_w2", 32'(ack_count2), 32'(304 % 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
